// File: rtl/sample_tx_pkg.sv
// Shared types and default sizing for the sample transmitter.
package sample_tx_pkg;

  localparam int unsigned WIN_DEF   = 16;
  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned CNT_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock FIFO with first-word fall-through head and registered flags.
module sample_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_next;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Next occupancy; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop)
      count_next = count + (AW+1)'(1);
    else if (do_pop && !do_push)
      count_next = count - (AW+1)'(1);
  end

  // Storage array write; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and flags; flags are derived from the next count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/sample_tx.sv
// Paced burst transmitter: buffers samples and emits one every rate_div+1 clocks.
module sample_tx
  import sample_tx_pkg::*;
#(
  parameter int unsigned WIN   = WIN_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIN-1:0]   wr_data,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [CNT_W-1:0] rate_div,
  output logic             val_out,
  output logic [WIN-1:0]   data_out,
  output logic             busy,
  output logic             done,
  output logic             full,
  output logic             empty,
  output logic             underrun,
  output logic             overflow,
  output logic [CNT_W-1:0] sent_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] rate_q;
  logic [CNT_W-1:0] div_cnt;
  logic [WIN-1:0]   head;
  logic [AW:0]      fifo_count;
  logic             has_data;
  logic             start_ok;
  logic             emit;
  logic             starve;
  logic             drop;

  assign has_data = (fifo_count != '0);
  assign drop     = wr_en && full && !emit;

  sample_fifo #(
    .W     (WIN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (emit),
    .din   (wr_data),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next state and per-cycle control; abort wins over emission.
  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    emit       = 1'b0;
    starve     = 1'b0;
    case (state)
      IDLE: begin
        if (start && (burst_len != '0)) begin
          start_ok   = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (div_cnt == '0) begin
          if (has_data) begin
            emit = 1'b1;
            if ((sent_cnt + CNT_W'(1)) == len_q)
              state_next = DONE;
          end else begin
            starve = 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs, burst counters and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_out  <= 1'b0;
      data_out <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      sent_cnt <= '0;
      div_cnt  <= '0;
      len_q    <= '0;
      rate_q   <= '0;
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      val_out  <= emit;
      data_out <= emit ? head : '0;
      done     <= (state == DONE) && !abort;
      busy     <= (state_next != IDLE);
      if (start_ok) begin
        len_q    <= burst_len;
        rate_q   <= rate_div;
        div_cnt  <= '0;
        sent_cnt <= '0;
      end else if (emit) begin
        sent_cnt <= sent_cnt + CNT_W'(1);
        div_cnt  <= rate_q;
      end else if ((state == RUN) && (div_cnt != '0)) begin
        div_cnt <= div_cnt - CNT_W'(1);
      end
      if (starve)
        underrun <= 1'b1;
      if (drop)
        overflow <= 1'b1;
    end
  end

endmodule

// File: doc/sample_tx.md
SAMPLE_TX -- requirements
Module: sample_tx

Interface
REQ-001 SHALL have parameter WIN, default 16: sample width in bits, signed two's complement.
REQ-002 SHALL have parameter DEPTH, default 16: FIFO entries, power of two, minimum 2.
REQ-003 SHALL have parameter CNT_W, default 12: width of the burst-length, divider and sent counters.
REQ-004 SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  push wr_data into FIFO.
- wr_data  in  WIN  signed sample to buffer.
- start  in  1  begin burst; honoured only in IDLE.
- abort  in  1  terminate burst.
- burst_len  in  CNT_W  samples per burst; sampled with start.
- rate_div  in  CNT_W  sample interval minus one, in clocks; sampled with start.
- val_out  out  1  data_out valid, one cycle per sample.
- data_out  out  WIN  signed sample; zero whenever val_out=0.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse after the last sample of a burst.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- underrun  out  1  sticky: FIFO empty when a sample was due.
- overflow  out  1  sticky: write was dropped because FIFO was full.
- sent_cnt  out  CNT_W  samples emitted in the current or last burst.

Function
REQ-005 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-006 IDLE -> RUN SHALL occur when start=1 and burst_len!=0; on that edge burst_len and rate_div are latched, div_cnt is loaded with 0, and sent_cnt is cleared.
REQ-007 IDLE SHALL ignore start when burst_len=0, and RUN/DONE SHALL ignore start.
REQ-008 In RUN, when div_cnt!=0, div_cnt SHALL decrement each cycle.
REQ-009 In RUN, when div_cnt=0 and the FIFO is not empty, the next edge SHALL:
- set val_out=1 and data_out=FIFO head;
- pop the FIFO;
- increment sent_cnt;
- reload div_cnt with the latched rate_div.
REQ-010 In RUN, when div_cnt=0 and the FIFO is empty, the block SHALL set underrun and emit nothing, retrying every cycle; the interval is not restarted.
REQ-011 The emitted-sample spacing SHALL be rate_div+1 clocks; rate_div=0 gives back-to-back val_out.
REQ-012 The first val_out SHALL occur one clock after the start edge when the FIFO is non-empty.
REQ-013 On the edge emitting sample number burst_len, state SHALL go to DONE; DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-014 abort=1 in RUN or DONE SHALL force IDLE on the next edge with no val_out and no done; FIFO contents and sent_cnt SHALL be kept; abort SHALL take priority over emission.
REQ-015 val_out SHALL be 0 and data_out SHALL be all-zero in every cycle without an emission.
REQ-016 A FIFO write SHALL be accepted when not full, or when full with a pop in the same cycle; otherwise it SHALL be dropped and overflow set.
REQ-017 Simultaneous push and pop SHALL leave the occupancy unchanged; a pop SHALL never occur when empty.
REQ-018 FIFO pointers SHALL wrap modulo DEPTH; the occupancy counter SHALL be log2(DEPTH)+1 bits wide.
REQ-019 sent_cnt SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-020 rst=1 SHALL, at the next edge, set:
- state=IDLE;
- val_out=0, data_out=0, done=0;
- sent_cnt=0, div_cnt=0;
- FIFO occupancy=0, so empty=1 and full=0;
- underrun=0, overflow=0.
REQ-021 rst SHALL override all inputs, including start, abort and wr_en, in the same cycle; a reset mid-burst SHALL discard the burst and all buffered samples.

Structure
REQ-022 Package sample_tx_pkg SHALL hold the FSM state enumeration (IDLE/RUN/DONE) and default constants for WIN, DEPTH and CNT_W.
REQ-023 The buffer SHALL be a sub-module sample_fifo: synchronous, single clock, first-word fall-through head, with full/empty/count outputs.
REQ-024 All outputs SHALL be registered.

Verification
REQ-025 Stimulus: push 4 samples (100, -1, 32767, -32768), start with burst_len=4, rate_div=0. Required: val_out high 4 consecutive cycles starting 1 clock after start, in that order; done 1 cycle later; sent_cnt=4; empty=1.
REQ-026 Stimulus: push 3 samples, start with burst_len=3, rate_div=4. Required: val_out pulses exactly 5 clocks apart; data_out=0 between pulses.
REQ-027 Stimulus: push 1 sample, start with burst_len=3, rate_div=0, push 2 more after 5 cycles. Required: underrun=1; samples 2 and 3 emitted on the first cycles after their arrival; done pulses once.
REQ-028 Stimulus: push DEPTH+2 samples with no burst running. Required: full=1 after DEPTH pushes; overflow=1; only the first DEPTH samples are later emitted.
REQ-029 Stimulus: abort in a burst_len=8 run after 3 samples. Required: IDLE on the next cycle; done never asserted; sent_cnt=3; remaining 5 samples still buffered.
REQ-030 Stimulus: rst mid-burst with start=1 and wr_en=1 held high. Required: all REQ-020 values hold; no val_out afterward until a new push and start.
